// File: rtl/xup_logic_pkg.sv
// Shared definitions for the xup logic-vector blocks.
//   - MODE_* : bitwise operation select codes
//   - state_e: burst controller state encoding
//   - cnt_w(): width of a counter able to hold size*words ones
package xup_logic_pkg;

  localparam logic [1:0] MODE_XNOR = 2'b00;
  localparam logic [1:0] MODE_XOR  = 2'b01;
  localparam logic [1:0] MODE_AND  = 2'b10;
  localparam logic [1:0] MODE_OR   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  function automatic int cnt_w(input int size, input int words);
    return $clog2(size * words + 1);
  endfunction

endpackage

// File: rtl/xup_popcount.sv
// Combinational ones-count of a SIZE-bit vector.
//   vec_i : input vector
//   cnt_o : number of set bits, OUT_W wide (zero-extended)
module xup_popcount #(
  parameter int SIZE  = 8,
  parameter int OUT_W = $clog2(SIZE + 1)
) (
  input  logic [SIZE-1:0]  vec_i,
  output logic [OUT_W-1:0] cnt_o
);

  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < SIZE; i++) begin
      cnt_o = cnt_o + OUT_W'(vec_i[i]);
    end
  end

endmodule

// File: rtl/xup_logic_vector_acc.sv
// Burst pattern-compare / match-count engine.
// Applies XNOR/XOR/AND/OR (mode latched on start) to WORDS operand pairs,
// registers each result and accumulates the popcount of all results.
//   clk, reset_n        : clock, async active-low reset
//   start, mode         : begin burst (IDLE only), operation select
//   in_valid / in_ready : operand handshake (ready only in RUN)
//   a, b                : operands
//   y, y_valid          : registered result of last accepted word + pulse
//   match_cnt           : running popcount total of the burst
//   all_match           : every result bit of the burst was 1 (valid from done)
//   done, busy          : burst-complete pulse, controller not idle
module xup_logic_vector_acc
  import xup_logic_pkg::*;
#(
  parameter int SIZE  = 8,
  parameter int WORDS = 4,
  localparam int CNT_W = cnt_w(SIZE, WORDS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SIZE-1:0]  a,
  input  logic [SIZE-1:0]  b,
  output logic [SIZE-1:0]  y,
  output logic             y_valid,
  output logic [CNT_W-1:0] match_cnt,
  output logic             all_match,
  output logic             done,
  output logic             busy
);

  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int MAX_C = SIZE * WORDS;

  state_e           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [SIZE-1:0]  y_q, y_d;
  logic             yv_q, yv_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             all_q, all_d;

  logic [SIZE-1:0]  res;
  logic [CNT_W-1:0] pc;
  logic [CNT_W-1:0] sum;
  logic             last;

  always_comb begin
    case (mode_q)
      MODE_XNOR: res = ~(a ^ b);
      MODE_XOR:  res = a ^ b;
      MODE_AND:  res = a & b;
      default:   res = a | b;
    endcase
  end

  xup_popcount #(.SIZE(SIZE), .OUT_W(CNT_W)) u_pc (
    .vec_i (res),
    .cnt_o (pc)
  );

  assign sum  = cnt_q + pc;
  assign last = (idx_q == IDX_W'(WORDS - 1));

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    idx_d   = idx_q;
    y_d     = y_q;
    yv_d    = 1'b0;
    cnt_d   = cnt_q;
    all_d   = all_q;
    case (state_q)
      ST_IDLE: begin
        // in_valid is ignored here, even together with start
        if (start) begin
          mode_d  = mode;
          idx_d   = '0;
          cnt_d   = '0;
          all_d   = 1'b0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (in_valid) begin
          y_d   = res;
          yv_d  = 1'b1;
          cnt_d = sum;
          if (last) begin
            // index holds on the last word so it never wraps mid-burst
            state_d = ST_DONE;
            all_d   = (sum == CNT_W'(MAX_C));
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      mode_q  <= '0;
      idx_q   <= '0;
      y_q     <= '0;
      yv_q    <= 1'b0;
      cnt_q   <= '0;
      all_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      y_q     <= y_d;
      yv_q    <= yv_d;
      cnt_q   <= cnt_d;
      all_q   <= all_d;
    end
  end

  assign in_ready  = (state_q == ST_RUN);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign y         = y_q;
  assign y_valid   = yv_q;
  assign match_cnt = cnt_q;
  assign all_match = all_q;

endmodule

// File: tb/tb_xup_logic_vector_acc.sv
module tb_xup_logic_vector_acc;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [1:0] mode;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a, b, y;
  logic       y_valid;
  logic [5:0] match_cnt;
  logic       all_match, done, busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] y;
    logic [5:0] cnt;
    logic       done;
    logic       all;
  } exp_t;

  exp_t sb[$];

  xup_logic_vector_acc #(.SIZE(8), .WORDS(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .y         (y),
    .y_valid   (y_valid),
    .match_cnt (match_cnt),
    .all_match (all_match),
    .done      (done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: compare every presented result against the scoreboard head
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (y_valid === 1'b1) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_y_valid: got y=%0h cnt=%0d, expected no output", y, match_cnt);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("y", 32'(y), 32'(e.y));
          check("match_cnt", 32'(match_cnt), 32'(e.cnt));
          check("done", 32'(done), 32'(e.done));
          check("all_match", 32'(all_match), 32'(e.all));
        end
      end else if (done === 1'b1) begin
        total++;
        bad++;
        $display("FAIL done_without_y_valid: got done=1, expected 0");
      end
    end
  end

  task automatic do_start(input logic [1:0] m);
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // present one word and push the hand-computed response on acceptance
  task automatic word(input logic [7:0] wa, input logic [7:0] wb, input logic [7:0] ey,
                      input logic [5:0] ec, input logic ed, input logic eall);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    a = wa;
    b = wb;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL in_ready_timeout: got in_ready=%b, expected 1", in_ready);
      in_valid = 1'b0;
    end else begin
      sb.push_back('{ey, ec, ed, eall});
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b1; mode = 2'b00; in_valid = 1'b1; a = 8'hFF; b = 8'hFF;
    repeat (3) @(negedge clk);
    check("rst_y", 32'(y), 0);
    check("rst_y_valid", 32'(y_valid), 0);
    check("rst_match_cnt", 32'(match_cnt), 0);
    check("rst_all_match", 32'(all_match), 0);
    check("rst_done", 32'(done), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    start = 1'b0;
    reset_n = 1'b1;
    // in_valid stays high in IDLE: nothing may be accepted
    repeat (3) @(negedge clk);
    check("idle_busy", 32'(busy), 0);
    check("idle_in_ready", 32'(in_ready), 0);
    in_valid = 1'b0;

    // XNOR, equal operands
    do_start(2'b00);
    word(8'hA5, 8'hA5, 8'hFF, 6'd8,  1'b0, 1'b0);
    word(8'hA5, 8'hA5, 8'hFF, 6'd16, 1'b0, 1'b0);
    word(8'hA5, 8'hA5, 8'hFF, 6'd24, 1'b0, 1'b0);
    word(8'hA5, 8'hA5, 8'hFF, 6'd32, 1'b1, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("xnor_idle_busy", 32'(busy), 0);
    check("xnor_hold_cnt", 32'(match_cnt), 32);
    check("xnor_hold_all", 32'(all_match), 1);
    check("xnor_hold_y", 32'(y), 32'hFF);

    // XOR
    do_start(2'b01);
    check("xor_start_clr_cnt", 32'(match_cnt), 0);
    check("xor_start_keeps_y", 32'(y), 32'hFF);
    word(8'h0F, 8'hFF, 8'hF0, 6'd4,  1'b0, 1'b0);
    word(8'h0F, 8'hFF, 8'hF0, 6'd8,  1'b0, 1'b0);
    word(8'h0F, 8'hFF, 8'hF0, 6'd12, 1'b0, 1'b0);
    word(8'h0F, 8'hFF, 8'hF0, 6'd16, 1'b1, 1'b0);
    @(negedge clk);

    // AND with two idle cycles between words
    do_start(2'b10);
    for (int i = 0; i < 4; i++) begin
      word(8'hFF, 8'h03, 8'h03, 6'(2 * (i + 1)), i == 3, 1'b0);
      if (i < 3) begin
        repeat (2) @(negedge clk);
        check("gap_hold_cnt", 32'(match_cnt), 32'(2 * (i + 1)));
        check("gap_busy", 32'(busy), 1);
      end
    end
    @(negedge clk);
    check("and_final_cnt", 32'(match_cnt), 8);

    // start + mode=OR pulsed mid-RUN must be ignored
    do_start(2'b00);
    word(8'hF0, 8'hF0, 8'hFF, 6'd8, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b1;
    mode  = 2'b11;
    @(negedge clk);
    start = 1'b0;
    word(8'hF0, 8'h0F, 8'h00, 6'd8,  1'b0, 1'b0);
    word(8'h3C, 8'h3C, 8'hFF, 6'd16, 1'b0, 1'b0);
    word(8'h00, 8'h01, 8'hFE, 6'd23, 1'b1, 1'b0);
    mode = 2'b00;
    @(negedge clk);

    // reset mid-burst
    do_start(2'b00);
    word(8'hFF, 8'hFF, 8'hFF, 6'd8,  1'b0, 1'b0);
    word(8'hFF, 8'hFF, 8'hFF, 6'd16, 1'b0, 1'b0);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_cnt", 32'(match_cnt), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_y", 32'(y), 0);
    @(negedge clk);
    reset_n = 1'b1;
    in_valid = 1'b1;
    repeat (2) @(negedge clk);
    check("postrst_needs_start", 32'(busy), 0);
    in_valid = 1'b0;
    do_start(2'b00);
    word(8'h00, 8'hFF, 8'h00, 6'd0, 1'b0, 1'b0);
    word(8'h00, 8'hFF, 8'h00, 6'd0, 1'b0, 1'b0);
    word(8'h00, 8'hFF, 8'h00, 6'd0, 1'b0, 1'b0);
    word(8'h00, 8'hFF, 8'h00, 6'd0, 1'b1, 1'b0);
    begin
      int n;
      n = 0;
      while (sb.size() != 0 && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    @(negedge clk);
    check("final_all_match", 32'(all_match), 0);
    check("final_busy", 32'(busy), 0);
    check("scoreboard_drained", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/xup_logic_vector_acc.md
Name: xup_logic_vector_acc

Overview:
- Sequential successor to the library's combinational gate-vector cells.
- Applies a selectable bitwise operation (XNOR/XOR/AND/OR) to SIZE-bit operand pairs and registers each per-word result.
- Accepts a burst of WORDS operand pairs under a valid/ready handshake and accumulates the population count of all results.
- Reports the total count, an all-ones flag and a done pulse; used as a pattern-compare / match-count engine in lab designs.

Parameters:
- SIZE, 8, operand and result width in bits (>=1)
- WORDS, 4, operand pairs per burst (>=1)

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- start  input  1  begin a burst; sampled only in IDLE
- mode  input  2  operation: 00 XNOR, 01 XOR, 10 AND, 11 OR; latched on start
- in_valid  input  1  a/b word presented
- in_ready  output  1  block accepts a word this cycle
- a  input  SIZE  operand A
- b  input  SIZE  operand B
- y  output  SIZE  registered bitwise result of last accepted word
- y_valid  output  1  one-cycle pulse, y updated
- match_cnt  output  CNT_W  running popcount total, CNT_W = $clog2(SIZE*WORDS+1)
- all_match  output  1  match_cnt == SIZE*WORDS, valid from done
- done  output  1  one-cycle pulse, burst complete
- busy  output  1  state != IDLE

Behaviour:
- Reset (async, reset_n=0): state IDLE; y, y_valid, match_cnt, all_match, done, busy, in_ready, word counter, latched mode all 0.
- States: IDLE, RUN, DONE; Moore outputs.
  - IDLE: in_ready=0, busy=0. start=1 -> latch mode, clear match_cnt, all_match and word counter, go RUN.
  - RUN: in_ready=1, busy=1.
  - DONE: in_ready=0, busy=1, done=1 for exactly one cycle, then IDLE.
- Accept = in_valid & in_ready (RUN only). On the accepting edge:
  - y <= op(a,b) with the latched mode.
  - y_valid <= 1.
  - match_cnt <= match_cnt + popcount(op(a,b)).
  - word counter +1.
  - If this is word WORDS-1: go DONE; all_match <= (new match_cnt == SIZE*WORDS).
- y_valid is 0 on any cycle without an accept on the previous edge.
- Latency: y/y_valid/match_cnt one cycle after accept. done coincides with the y_valid of the last word.
- in_valid=0 in RUN: all state holds, with no timeout.
- y, match_cnt and all_match hold after done until the next accepted start. y is not cleared by start.
- start in RUN or DONE: ignored, and the latched mode is unaffected.
- start and in_valid both high in IDLE: only start takes effect. That word is not accepted (in_ready=0); the first accept can occur on the next cycle.
- mode changes while busy have no effect.
- WORDS=1: a single accept goes RUN->DONE.
- Word counter width max(1,$clog2(WORDS)). It never wraps within a burst; it is cleared on start.
- match_cnt cannot overflow by construction (CNT_W sizing). Popcount is zero-extended to CNT_W before the add.
- reset_n asserted mid-burst: immediate return to reset values. A partial burst is discarded, and the next burst requires a new start.

Decomposition:
- Package xup_logic_pkg:
  - mode constants MODE_XNOR=2'b00, MODE_XOR=2'b01, MODE_AND=2'b10, MODE_OR=2'b11
  - state encoding IDLE/RUN/DONE
  - function for CNT_W
- Sub-module xup_popcount #(SIZE, OUT_W): combinational ones-count of a SIZE-bit vector. Reused by future vector blocks.
- Bitwise op is a case on the latched mode inside the top module.

Test Plan (SIZE=8, WORDS=4):
- Reset: hold reset_n=0, drive start=1, in_valid=1 -> all outputs 0, in_ready=0. Release -> still IDLE, busy=0.
- XNOR equal: start with mode=00, then a=b=8'hA5 for 4 consecutive cycles -> y=8'hFF with y_valid on each of the 4 cycles; match_cnt 8,16,24,32; done=1 and all_match=1 on the cycle of the 4th y_valid; IDLE next cycle.
- XOR mode: mode=01, a=8'h0F, b=8'hFF x4 -> y=8'hF0 each, final match_cnt=16, all_match=0, done one pulse.
- Gapped input: mode=10, a=8'hFF, b=8'h03 with in_valid low 2 cycles between words -> counters hold during gaps; done only after the 4th accept; match_cnt=8.
- Ignored controls: in_valid=1 in IDLE -> no y_valid. start=1 and mode=11 pulsed mid-RUN -> burst continues in the originally latched mode, word count unchanged.
- Reset mid-burst: after 2 accepted words, pulse reset_n low -> match_cnt=0, busy=0. A new start plus 4 words (XNOR, a=8'h00, b=8'hFF) gives match_cnt=0 and all_match=0.
